// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S transmitter slice.
package i2s_pkg;

    typedef enum logic {
        I2S_STD = 1'b0,
        I2S_LJ  = 1'b1
    } i2s_mode_e;

    // Width of a level counter able to hold 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Registered stereo-frame FIFO. Refuses a push at full even if a pop happens
// on the same cycle, so the write never depends on the read side.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      pop,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [level_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx_stream.sv
// Stereo I2S / left-justified transmitter running entirely on mclk. The bit
// clock and word clock are derived here; frames come from a small FIFO and
// are shifted out MSB-first into zero-padded slots.
module i2s_tx_stream
    import i2s_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int SLOT_W     = 32,
    parameter int MCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MODE       = 0
) (
    input  logic                           mclk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_W-1:0]              s_left,
    input  logic [DATA_W-1:0]              s_right,
    output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic                           underrun,
    input  logic                           underrun_clr,
    output logic                           sdout,
    output logic                           mclk_out,
    output logic                           sclk_out,
    output logic                           lrclk_out
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int DIV_W   = $clog2(MCLK_DIV);

    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_next;
    logic [FRAME_W-1:0]  shift_q;
    logic [FRAME_W-1:0]  frame_load;
    logic                dly_q;
    logic                div_half;
    logic                div_last;
    logic                fall_evt;
    logic                bit_last;
    logic                load;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_W-1:0]   rd_left;
    logic [DATA_W-1:0]   rd_right;

    assign mclk_out = mclk;
    assign s_ready  = !fifo_full;

    assign div_half = (div_cnt == DIV_W'(MCLK_DIV / 2 - 1));
    assign div_last = (div_cnt == DIV_W'(MCLK_DIV - 1));
    assign fall_evt = en && div_last;
    assign bit_last = (bit_cnt == CNT_W'(FRAME_W - 1));
    assign bit_next = bit_last ? '0 : bit_cnt + CNT_W'(1);
    assign load     = fall_evt && bit_last;

    // Shifts avoid a zero-width pad when SLOT_W equals DATA_W.
    assign frame_load = (FRAME_W'(rd_left) << (FRAME_W - DATA_W)) |
                        (FRAME_W'(rd_right) << (SLOT_W - DATA_W));

    assign sdout = (MODE == int'(I2S_LJ)) ? shift_q[FRAME_W-1] : dly_q;

    i2s_sample_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (mclk),
        .rst   (rst),
        .push  (s_valid),
        .wdata ({s_left, s_right}),
        .pop   (load),
        .rdata ({rd_left, rd_right}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // mclk divider producing a registered bit clock.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            sclk_out <= 1'b0;
        end else if (en) begin
            div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
            if (div_half) begin
                sclk_out <= 1'b1;
            end else if (div_last) begin
                sclk_out <= 1'b0;
            end
        end
    end

    // Serial state advances only on bit-clock falling edges.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= CNT_W'(FRAME_W - 1);
            lrclk_out <= 1'b1;
            shift_q   <= '0;
            dly_q     <= 1'b0;
        end else if (fall_evt) begin
            bit_cnt   <= bit_next;
            lrclk_out <= (bit_next >= CNT_W'(SLOT_W));
            dly_q     <= shift_q[FRAME_W-1];
            if (bit_last) begin
                shift_q <= fifo_empty ? '0 : frame_load;
            end else begin
                shift_q <= shift_q << 1;
            end
        end
    end

    // Sticky underrun; a set in the same cycle as a clear keeps it high.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (load && fifo_empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule
